// File: rtl/alu_fsm_pkg.sv
// Shared types and constants for the alu_fsm instruction sequencer.
//   state_t     : sequencer states
//   instr_t     : instruction fields latched on acceptance
//   ctl_out_t   : registered control-strobe bundle driven onto the bus
//   is_illegal  : opcodes with the top bit set bypass the datapath
package alu_fsm_pkg;

  localparam int unsigned NREGS   = 4;
  localparam int unsigned OPW     = 4;
  localparam int unsigned CTLW    = 3;
  localparam int unsigned RIDXW   = 2;
  localparam int unsigned RFIELDW = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD1 = 3'd1,
    LOAD2 = 3'd2,
    EXEC  = 3'd3,
    WB    = 3'd4,
    DONE  = 3'd5
  } state_t;

  typedef struct packed {
    logic [CTLW-1:0]  ctl;
    logic [RIDXW-1:0] ri;
    logic [RIDXW-1:0] rj;
  } instr_t;

  typedef struct packed {
    logic             done;
    logic [NREGS-1:0] rd;
    logic [NREGS-1:0] wr;
    logic [CTLW-1:0]  ctl;
    logic             out_en;
    logic             win1;
    logic             win2;
    logic             alu_rd;
  } ctl_out_t;

  function automatic logic is_illegal(input logic [OPW-1:0] op);
    return op[OPW-1];
  endfunction

endpackage

// File: rtl/alu_fsm_if.sv
// Request and control-strobe bus between an instruction source, the
// alu_fsm sequencer, the register file and the ALU.
//   slave  : sequencer side (takes start/opCode/Ri/Rj, drives strobes)
//   master : requester/observer side
interface alu_fsm_if;
  import alu_fsm_pkg::*;

  logic                 start;
  logic [OPW-1:0]       opCode;
  logic [RFIELDW-1:0]   Ri;
  logic [RFIELDW-1:0]   Rj;
  logic                 done;
  logic                 R0_write, R0_read;
  logic                 R1_write, R1_read;
  logic                 R2_write, R2_read;
  logic                 R3_write, R3_read;
  logic [CTLW-1:0]      ALU_opControl;
  logic                 ALU_alu_out_en;
  logic                 ALU_writeIN1;
  logic                 ALU_writeIN2;
  logic                 ALU_read;

  modport slave (
    input  start, opCode, Ri, Rj,
    output done,
    output R0_write, R0_read, R1_write, R1_read,
    output R2_write, R2_read, R3_write, R3_read,
    output ALU_opControl, ALU_alu_out_en, ALU_writeIN1, ALU_writeIN2, ALU_read
  );

  modport master (
    output start, opCode, Ri, Rj,
    input  done,
    input  R0_write, R0_read, R1_write, R1_read,
    input  R2_write, R2_read, R3_write, R3_read,
    input  ALU_opControl, ALU_alu_out_en, ALU_writeIN1, ALU_writeIN2, ALU_read
  );

endinterface

// File: rtl/alu_fsm_start_capture.sv
// Captures start pulses of any width into the clk domain.
//   clk, rst_n : clock, async active-low reset
//   start_i    : asynchronous request pulse
//   ack_i      : one-cycle acceptance from the sequencer
//   pending_c  : a request is outstanding (combinational)
module alu_fsm_start_capture (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic ack_i,
  output logic pending_c
);

  logic req_q;
  logic sync1_q, sync2_q;
  logic ack_q;

  // The start pulse itself clocks the toggle so sub-cycle pulses are kept.
  always_ff @(posedge start_i or negedge rst_n) begin
    if (!rst_n) req_q <= 1'b0;
    else        req_q <= ~req_q;
  end

  // Synchronise the request toggle; ack toggles in the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      sync1_q <= req_q;
      sync2_q <= sync1_q;
      ack_q   <= ack_q ^ ack_i;
    end
  end

  // XOR after the synchroniser so an accepted request clears at once.
  assign pending_c = sync2_q ^ ack_q;

endmodule

// File: rtl/alu_fsm.sv
// Control sequencer for one ALU instruction: read Ri into ALU operand 1,
// read Rj into operand 2, execute, write the result back to Ri, pulse done.
//   clk   : system clock
//   reset : async active-low reset
//   bus   : alu_fsm_if.slave (start/opCode/Ri/Rj in, strobes and done out)
module alu_fsm
  import alu_fsm_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  alu_fsm_if.slave bus
);

  state_t   state_q, state_d;
  instr_t   instr_q, instr_d;
  ctl_out_t out_q, out_d;
  logic     pending_c;
  logic     ack_c;
  logic     unused_c;

  // Only the low index bits select a register.
  assign unused_c = ^{bus.Ri[RFIELDW-1:RIDXW], bus.Rj[RFIELDW-1:RIDXW]};

  alu_fsm_start_capture u_start_capture (
    .clk       (clk),
    .rst_n     (reset),
    .start_i   (bus.start),
    .ack_i     (ack_c),
    .pending_c (pending_c)
  );

  // State, latched fields and registered strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      instr_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      out_q   <= out_d;
    end
  end

  // Next state and strobe decode; strobes for a state appear one edge later.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    out_d   = '0;
    ack_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending_c) begin
          ack_c       = 1'b1;
          instr_d.ctl = bus.opCode[CTLW-1:0];
          instr_d.ri  = bus.Ri[RIDXW-1:0];
          instr_d.rj  = bus.Rj[RIDXW-1:0];
          state_d     = is_illegal(bus.opCode) ? DONE : LOAD1;
        end
      end
      LOAD1: begin
        out_d.rd[instr_q.ri] = 1'b1;
        out_d.win1           = 1'b1;
        out_d.ctl            = instr_q.ctl;
        state_d              = LOAD2;
      end
      LOAD2: begin
        out_d.rd[instr_q.rj] = 1'b1;
        out_d.win2           = 1'b1;
        out_d.ctl            = instr_q.ctl;
        state_d              = EXEC;
      end
      EXEC: begin
        out_d.out_en = 1'b1;
        out_d.ctl    = instr_q.ctl;
        state_d      = WB;
      end
      WB: begin
        out_d.wr[instr_q.ri] = 1'b1;
        out_d.alu_rd         = 1'b1;
        out_d.ctl            = instr_q.ctl;
        state_d              = DONE;
      end
      DONE: begin
        out_d.done = 1'b1;
        out_d.ctl  = instr_q.ctl;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.done           = out_q.done;
  assign bus.R0_read        = out_q.rd[0];
  assign bus.R1_read        = out_q.rd[1];
  assign bus.R2_read        = out_q.rd[2];
  assign bus.R3_read        = out_q.rd[3];
  assign bus.R0_write       = out_q.wr[0];
  assign bus.R1_write       = out_q.wr[1];
  assign bus.R2_write       = out_q.wr[2];
  assign bus.R3_write       = out_q.wr[3];
  assign bus.ALU_opControl  = out_q.ctl;
  assign bus.ALU_alu_out_en = out_q.out_en;
  assign bus.ALU_writeIN1   = out_q.win1;
  assign bus.ALU_writeIN2   = out_q.win2;
  assign bus.ALU_read       = out_q.alu_rd;

endmodule

// File: tb/tb_alu_fsm.sv
// Self-checking bench for alu_fsm: directed scenarios plus random
// instructions compared cycle by cycle against a behavioural model.
module tb_alu_fsm;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  alu_fsm_if bus ();

  alu_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed bus: {done, read[3:0], write[3:0], opControl, out_en, in1, in2, alu_read}
  function automatic logic [15:0] obs_vec();
    return {bus.done,
            bus.R3_read, bus.R2_read, bus.R1_read, bus.R0_read,
            bus.R3_write, bus.R2_write, bus.R1_write, bus.R0_write,
            bus.ALU_opControl, bus.ALU_alu_out_en,
            bus.ALU_writeIN1, bus.ALU_writeIN2, bus.ALU_read};
  endfunction

  // Expected bus in cycle k after the instruction's strobes begin.
  function automatic logic [15:0] exp_vec(input logic [3:0] op, input logic [1:0] ri,
                                          input logic [1:0] rj, input int k);
    logic [3:0] rd, wr;
    logic       dn, en, w1, w2, ar;
    logic [2:0] ctl;
    rd = 4'd0; wr = 4'd0; dn = 1'b0; en = 1'b0; w1 = 1'b0; w2 = 1'b0; ar = 1'b0;
    ctl = 3'(op % 8);
    if (op >= 8) begin
      dn = (k == 0);
    end else begin
      case (k)
        0: begin rd = 4'(1 << ri); w1 = 1'b1; end
        1: begin rd = 4'(1 << rj); w2 = 1'b1; end
        2: en = 1'b1;
        3: begin wr = 4'(1 << ri); ar = 1'b1; end
        4: dn = 1'b1;
        default: ;
      endcase
    end
    return {dn, rd, wr, ctl, en, w1, w2, ar};
  endfunction

  task automatic check(input string tag, input logic [15:0] exp);
    logic [15:0] obs;
    obs = obs_vec();
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Short start pulse strictly between two clock edges.
  task automatic pulse_start();
    #2 bus.start = 1'b1;
    #4 bus.start = 1'b0;
  endtask

  task automatic set_inputs(input logic [3:0] op, input logic [1:0] ri, input logic [1:0] rj);
    bus.opCode = op;
    bus.Ri     = {4'($urandom), ri};
    bus.Rj     = {4'($urandom), rj};
  endtask

  task automatic scramble();
    bus.opCode = 4'($urandom);
    bus.Ri     = 6'($urandom);
    bus.Rj     = 6'($urandom);
  endtask

  // Two synchroniser edges, then the acceptance edge; strobes follow.
  task automatic run_op(input logic [3:0] op, input logic [1:0] ri, input logic [1:0] rj,
                        input string tag);
    int n;
    n = (op >= 8) ? 1 : 5;
    set_inputs(op, ri, rj);
    pulse_start();
    for (int w = 0; w < 3; w++) begin
      step();
      check($sformatf("%s_wait%0d", tag, w), 16'h0);
    end
    scramble();
    for (int k = 0; k < n; k++) begin
      step();
      check($sformatf("%s_c%0d", tag, k), exp_vec(op, ri, rj, k));
    end
    step();
    check({tag, "_idle"}, 16'h0);
  endtask

  initial begin
    logic [3:0] rop;
    logic [1:0] rri, rrj;
    total = 0;
    bad   = 0;
    bus.start  = 1'b0;
    bus.opCode = 4'd0;
    bus.Ri     = 6'd0;
    bus.Rj     = 6'd0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1 check("reset_outputs", 16'h0);
    #21 reset = 1'b1;
    step();

    // Idle with no request
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("idle%0d", i), 16'h0);
    end

    run_op(4'd1, 2'd0, 2'd3, "short");
    run_op(4'd5, 2'd2, 2'd2, "same_reg");
    run_op(4'd9, 2'd1, 2'd3, "illegal");

    // Second request lands during EXEC of the first
    set_inputs(4'd3, 2'd3, 2'd0);
    pulse_start();
    for (int w = 0; w < 3; w++) begin
      step();
      check($sformatf("busy_wait%0d", w), 16'h0);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("busy_a_c%0d", k), exp_vec(4'd3, 2'd3, 2'd0, k));
    end
    set_inputs(4'd2, 2'd1, 2'd2);
    pulse_start();
    for (int k = 3; k < 5; k++) begin
      step();
      check($sformatf("busy_a_c%0d", k), exp_vec(4'd3, 2'd3, 2'd0, k));
    end
    step();
    check("busy_gap", 16'h0);
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("busy_b_c%0d", k), exp_vec(4'd2, 2'd1, 2'd2, k));
    end
    step();
    check("busy_idle", 16'h0);

    // Reset while LOAD2 strobes are on the bus
    set_inputs(4'd6, 2'd1, 2'd3);
    pulse_start();
    for (int w = 0; w < 3; w++) step();
    step();
    check("rst_c0", exp_vec(4'd6, 2'd1, 2'd3, 0));
    step();
    check("rst_c1", exp_vec(4'd6, 2'd1, 2'd3, 1));
    #2 reset = 1'b0;
    #1 check("rst_immediate", 16'h0);
    #2 reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("rst_after%0d", i), 16'h0);
    end

    // Random instructions
    for (int i = 0; i < 24; i++) begin
      rop = 4'($urandom_range(15, 0));
      rri = 2'($urandom_range(3, 0));
      rrj = 2'($urandom_range(3, 0));
      run_op(rop, rri, rrj, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
